// File: rtl/agex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : agex_hazard_ctrl
// Description : Register scoreboard and branch-flush controller sitting at the
//               DE->AGEX boundary. Counts in-flight writers per architectural
//               register between issue and writeback, stalls FE/DE on RAW and
//               counter-overflow hazards, and squashes FE/DE for FLUSH_CYCLES
//               cycles after a taken branch resolves in AGEX.
// Options     : HAZARD_STATS_EN - adds 32-bit stall_cnt / flush_cnt counters.
// Ports       : clk, reset_n        clock, async active-low reset
//               de_*                DE latch instruction (sources, dest, valid)
//               agex_br_taken       taken-branch redirect from AGEX
//               wb_valid/wr_en/rd   retiring register write
//               stall/flush/issue   combinational pipeline controls
//               sb_err              sticky retire-underflow flag
//               stall_cnt/flush_cnt statistics (HAZARD_STATS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module agex_hazard_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int REGNO_BITS   = 5,
    parameter int CNT_BITS     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  de_valid,
    input  logic [REGNO_BITS-1:0] de_rs1,
    input  logic [REGNO_BITS-1:0] de_rs2,
    input  logic                  de_rs1_used,
    input  logic                  de_rs2_used,
    input  logic                  de_wr_en,
    input  logic [REGNO_BITS-1:0] de_rd,
    input  logic                  agex_br_taken,
    input  logic                  wb_valid,
    input  logic                  wb_wr_en,
    input  logic [REGNO_BITS-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush,
    output logic                  issue,
    output logic                  sb_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    // The flush down-counter holds at most FLUSH_CYCLES-2.
    localparam int FCNT_BITS = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
    localparam logic [FCNT_BITS-1:0] FCNT_LOAD =
        (FLUSH_CYCLES > 1) ? FCNT_BITS'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [FCNT_BITS-1:0]  fcnt_q, fcnt_d;
    logic [CNT_BITS-1:0]   cnt_q [NUM_REGS];
    logic [CNT_BITS-1:0]   cnt_d [NUM_REGS];
    logic                  sb_err_q, sb_err_d;

    logic w_hazard;
    logic w_flush;
    logic w_stall;
    logic w_issue;
    logic w_inc_sel;
    logic w_dec_sel;

    // Hazards look only at registered counts, so a retire unblocks its
    // dependent one cycle later (no same-cycle bypass).
    assign w_hazard = (de_rs1_used && (de_rs1 != '0) && (cnt_q[de_rs1] != '0)) ||
                      (de_rs2_used && (de_rs2 != '0) && (cnt_q[de_rs2] != '0)) ||
                      (de_wr_en    && (de_rd  != '0) && (cnt_q[de_rd]  == CNT_MAX));

    // A branch seen while already flushing is ignored: AGEX holds bubbles.
    assign w_flush = ((state_q == ST_RUN) && agex_br_taken) || (state_q == ST_FLUSH);
    assign w_stall = de_valid && !w_flush && w_hazard;
    assign w_issue = de_valid && !w_flush && !w_hazard;

    assign stall  = w_stall;
    assign flush  = w_flush;
    assign issue  = w_issue;
    assign sb_err = sb_err_q;

    // Flushed DE instructions never issue, hence never increment.
    assign w_inc_sel = w_issue && de_wr_en && (de_rd != '0);
    assign w_dec_sel = wb_valid && wb_wr_en && (wb_rd != '0);

    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_inc_sel && (de_rd == REGNO_BITS'(i)) &&
                !(w_dec_sel && (wb_rd == REGNO_BITS'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end else if (w_dec_sel && (wb_rd == REGNO_BITS'(i)) &&
                         !(w_inc_sel && (de_rd == REGNO_BITS'(i))) &&
                         (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
            end
        end
    end

    // Retire of a register with no writer in flight is an underflow.
    assign sb_err_d = sb_err_q || (w_dec_sel && (cnt_q[wb_rd] == '0));

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (agex_br_taken && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FCNT_BITS'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            sb_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            sb_err_q <= sb_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic        w_br_accept;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counts accepted branches only, i.e. the RUN->flush entry cycle.
    assign w_br_accept = (state_q == ST_RUN) && agex_br_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, w_stall};
        flush_cnt_d = flush_cnt_q + {31'd0, w_br_accept};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_agex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_agex_hazard_ctrl
// Description : Directed scoreboard bench for agex_hazard_ctrl (FLUSH_CYCLES=2)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agex_hazard_ctrl;

    localparam int SEL_CTRL  = 0;  // {stall, flush, issue}
    localparam int SEL_ERR   = 1;
    localparam int SEL_STALL = 2;
    localparam int SEL_FLUSH = 3;

    logic       clk;
    logic       reset_n;
    logic       de_valid;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       de_rs1_used, de_rs2_used, de_wr_en;
    logic       agex_br_taken;
    logic       wb_valid, wb_wr_en;
    logic [4:0] wb_rd;
    logic       stall, flush, issue, sb_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    agex_hazard_ctrl #(
        .NUM_REGS(32), .REGNO_BITS(5), .CNT_BITS(2), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_wr_en(de_wr_en), .de_rd(de_rd),
        .agex_br_taken(agex_br_taken),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .stall(stall), .flush(flush), .issue(issue), .sb_err(sb_err)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        sb_entry_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic push_ctrl(input string tag, input logic s, input logic f, input logic i);
        push(tag, SEL_CTRL, {29'd0, s, f, i});
    endtask

    task automatic check_pending();
        sb_entry_t   e;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_CTRL: got = {29'd0, stall, flush, issue};
                SEL_ERR:  got = {31'd0, sb_err};
`ifdef HAZARD_STATS_EN
                SEL_STALL: got = stall_cnt;
                SEL_FLUSH: got = flush_cnt;
`endif
                default:  got = 32'hDEAD_BEEF;
            endcase
            n_vec++;
            assert (got === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.exp);
            end
        end
    endtask

    // Inputs are applied just after a rising edge; outputs checked at the
    // following falling edge.
    task automatic tick();
        @(negedge clk);
        check_pending();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
        de_wr_en = 0; de_rd = 0; agex_br_taken = 0;
        wb_valid = 0; wb_wr_en = 0; wb_rd = 0;
    endtask

    task automatic writer(input logic [4:0] rd);
        clr(); de_valid = 1; de_wr_en = 1; de_rd = rd;
    endtask

    task automatic reader1(input logic [4:0] rs);
        clr(); de_valid = 1; de_rs1 = rs; de_rs1_used = 1;
    endtask

    task automatic retire(input logic [4:0] rd);
        wb_valid = 1; wb_wr_en = 1; wb_rd = rd;
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        @(posedge clk); #1;
        push_ctrl("reset_ctrl", 0, 0, 0);
        push("reset_sb_err", SEL_ERR, 0);
`ifdef HAZARD_STATS_EN
        push("reset_stall_cnt", SEL_STALL, 0);
        push("reset_flush_cnt", SEL_FLUSH, 0);
`endif
        check_pending();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // RAW on x5
        writer(5);                 push_ctrl("raw_writer", 0, 0, 1); tick();
        reader1(5);                push_ctrl("raw_stall1", 1, 0, 0); tick();
        reader1(5); retire(5);     push_ctrl("raw_stall_wb", 1, 0, 0); tick();
        reader1(5);                push_ctrl("raw_issue", 0, 0, 1); tick();

        // x0 never tracked
        writer(0);                 push_ctrl("x0_writer", 0, 0, 1); tick();
        clr(); de_valid = 1; de_rs2 = 0; de_rs2_used = 1;
                                   push_ctrl("x0_reader", 0, 0, 1); tick();

        // Saturation on x7
        writer(7);                 push_ctrl("sat_w1", 0, 0, 1); tick();
        writer(7);                 push_ctrl("sat_w2", 0, 0, 1); tick();
        writer(7);                 push_ctrl("sat_w3", 0, 0, 1); tick();
        writer(7);                 push_ctrl("sat_w4_stall", 1, 0, 0); tick();
        writer(7); retire(7);      push_ctrl("sat_w4_wb", 1, 0, 0); tick();
        writer(7);                 push_ctrl("sat_w4_issue", 0, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            clr(); retire(7);      push_ctrl("sat_drain", 0, 0, 0); tick();
        end
        reader1(7);                push_ctrl("sat_drained", 0, 0, 1); tick();

        // Simultaneous issue + retire on x3
        writer(3);                 push_ctrl("sim_w1", 0, 0, 1); tick();
        writer(3); retire(3);      push_ctrl("sim_both", 0, 0, 1); tick();
        reader1(3);                push_ctrl("sim_still1", 1, 0, 0); tick();
        reader1(3); retire(3);     push_ctrl("sim_wb", 1, 0, 0); tick();
        reader1(3);                push_ctrl("sim_free", 0, 0, 1); tick();

        // Taken branch with a DE writer of x9; second branch ignored
        writer(9); agex_br_taken = 1; push_ctrl("br_t0", 0, 1, 0); tick();
        writer(9); agex_br_taken = 1; push_ctrl("br_t1", 0, 1, 0); tick();
        reader1(9);                push_ctrl("br_done_x9_free", 0, 0, 1); tick();

        // Spurious retire -> sticky sb_err
        clr(); retire(4);          push_ctrl("err_ctrl", 0, 0, 0);
                                   push("err_before", SEL_ERR, 0); tick();
        clr();                     push("err_set", SEL_ERR, 1); tick();
        clr();                     push("err_sticky", SEL_ERR, 1);
`ifdef HAZARD_STATS_EN
        push("stats_stall_cnt", SEL_STALL, 6);
        push("stats_flush_cnt", SEL_FLUSH, 1);
`endif
        tick();

        // Reset in the middle of a flush with x10 in flight
        writer(10);                push_ctrl("rst_w10", 0, 0, 1); tick();
        clr(); agex_br_taken = 1;  push_ctrl("rst_br", 0, 1, 0); tick();
        clr();                     push_ctrl("rst_in_flush", 0, 1, 0); check_pending();
        reset_n = 1'b0; #1;
        push_ctrl("rst_flush_gone", 0, 0, 0);
        push("rst_sb_err", SEL_ERR, 0);
`ifdef HAZARD_STATS_EN
        push("rst_stall_cnt", SEL_STALL, 0);
        push("rst_flush_cnt", SEL_FLUSH, 0);
`endif
        check_pending();
        reader1(10); #1;           push_ctrl("rst_x10_clear", 0, 0, 1); check_pending();
        @(posedge clk); #1;
        reset_n = 1'b1;
        reader1(10);               push_ctrl("post_rst_x10", 0, 0, 1);
                                   push("post_rst_err", SEL_ERR, 0); tick();

        clr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
